// File: rtl/decoder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Package    : decoder_pkg                                                 |
// | Description: Shared types and constants for the one-hot decoder/scanner. |
// |              State encoding of the decoder FSM, mode and scan-direction  |
// |              codes as seen on the top-level `mode` and `dir` pins.       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package decoder_pkg;

   // Decoder operating state
   typedef enum logic [1:0] {
      OFF    = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // Values of the `mode` input
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Values of the `dir` input
   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module     : scan_tick_gen                                               |
// | Description: Dwell counter for the auto-scan mode. Produces a step       |
// |              request `tick` once every max(dwell,1) running cycles.      |
// | Ports      : clk   - system clock                                        |
// |              rst   - asynchronous active-high reset (cnt = 0)            |
// |              clr   - synchronous clear of the counter (has priority)     |
// |              run   - count enable; tick can only assert while running    |
// |              dwell - cycles per step, 0 behaves as 1                     |
// |              tick  - combinational: step on the coming edge              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module scan_tick_gen
   import decoder_pkg::*;
#(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               run,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tick
);

   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] w_dw_m1;
   logic               w_terminal;

   // dw - 1 with dw = max(dwell, 1); never underflows, so the unsigned
   // compare below is always well defined.
   assign w_dw_m1 = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

   // Compared against the live dwell value: lowering dwell below the current
   // count makes the very next running edge a step.
   assign w_terminal = (r_cnt >= w_dw_m1);
   assign tick       = run && w_terminal;

   // The counter restarts on every step, so it never exceeds dw - 1 and the
   // increment cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (run) begin
         if (w_terminal) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DWELL_W'(1);
         end
      end
   end

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/onehot_decoder_scan.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module     : onehot_decoder_scan                                         |
// | Description: Registered SEL_W-to-OUT_W one-hot decoder with enable,      |
// |              direct-select capture and an auto-scan mode that steps the  |
// |              active output up/down every `dwell` cycles and pulses       |
// |              `wrap` when the index rolls over.                           |
// | Ports      : clk     - system clock                                      |
// |              rst     - asynchronous active-high reset                    |
// |              en      - 1 active, 0 output blanked with state held        |
// |              mode    - 0 DIRECT, 1 SCAN                                  |
// |              dir     - scan direction, 0 up, 1 down                      |
// |              sel     - index captured in DIRECT mode                     |
// |              sel_vld - capture strobe for sel                            |
// |              dwell   - cycles per scan step (0 behaves as 1)             |
// |              out     - registered one-hot output                         |
// |              idx     - registered current index                          |
// |              wrap    - one-cycle pulse on scan roll-over                 |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module onehot_decoder_scan
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int OUT_W   = 2**SEL_W,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               dir,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_vld,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   out,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap
);

   // OUT_W may equal 2**SEL_W, so the range check needs one extra bit.
   localparam logic [SEL_W:0]   C_OUT_W = (SEL_W+1)'(OUT_W);
   localparam logic [SEL_W-1:0] C_LAST  = SEL_W'(OUT_W - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_idx;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic [OUT_W-1:0]   r_out;
   logic               r_wrap;
   logic               w_wrap_nxt;
   logic               w_clr;
   logic               w_run;
   logic               w_tick;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state, a pure function of en/mode so any transition is legal
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = OFF;
      if (en) begin
         w_state_nxt = (mode == MODE_DIRECT) ? DIRECT : SCAN;
      end
   end

   // ------------------------------------------------------------------
   // Dwell counter control.
   // Counting only happens while staying in SCAN; the edge that enters SCAN
   // restarts the count so the first step lands dw cycles after entry.
   // DIRECT keeps the counter at zero; OFF freezes it.
   // ------------------------------------------------------------------
   assign w_run = (r_state == SCAN) && (w_state_nxt == SCAN);
   assign w_clr = ((w_state_nxt == SCAN) && (r_state != SCAN)) ||
                  (w_state_nxt == DIRECT);

   scan_tick_gen #(
      .DWELL_W (DWELL_W)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .run   (w_run),
      .dwell (dwell),
      .tick  (w_tick)
   );

   // ------------------------------------------------------------------
   // Next index and wrap flag. The action taken on an edge follows the
   // state being entered on that edge.
   // ------------------------------------------------------------------
   always_comb begin
      w_idx_nxt  = r_idx;
      w_wrap_nxt = 1'b0;
      case (w_state_nxt)
         DIRECT: begin
            // Out-of-range selects are dropped so idx never leaves 0..OUT_W-1
            if (sel_vld && ({1'b0, sel} < C_OUT_W)) begin
               w_idx_nxt = sel;
            end
         end
         SCAN: begin
            if (w_tick) begin
               if (dir == DIR_DN) begin
                  if (r_idx == '0) begin
                     w_idx_nxt  = C_LAST;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx - SEL_W'(1);
                  end
               end else begin
                  if (r_idx == C_LAST) begin
                     w_idx_nxt  = '0;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + SEL_W'(1);
                  end
               end
            end
         end
         default: begin
            // OFF: index held, no wrap
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output registers. out is decoded from the same next index that idx
   // loads, so the two can never disagree while enabled.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx  <= '0;
         r_out  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_idx  <= w_idx_nxt;
         r_wrap <= w_wrap_nxt;
         if (w_state_nxt == OFF) begin
            r_out <= '0;
         end else begin
            r_out <= OUT_W'(1) << w_idx_nxt;
         end
      end
   end

   assign out  = r_out;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule : onehot_decoder_scan
`default_nettype wire

// File: tb/tb_onehot_decoder_scan.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module     : tb_onehot_decoder_scan                                      |
// | Description: Self-checking bench for onehot_decoder_scan. One instance   |
// |              with OUT_W = 8 and one with OUT_W = 6. Expected out/idx/    |
// |              wrap values are queued as stimulus is applied and popped    |
// |              when the registered outputs are sampled.                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_onehot_decoder_scan;

   typedef struct packed {
      logic        en;
      logic        mode;
      logic        dir;
      logic [2:0]  sel;
      logic        vld;
      logic [23:0] dwell;
   } stim_t;

   typedef struct packed {
      logic [7:0] out;
      logic [2:0] idx;
      logic       wrap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        en8 = 1'b0, mode8 = 1'b0, dir8 = 1'b0, vld8 = 1'b0;
   logic [2:0]  sel8 = '0;
   logic [23:0] dwell8 = '0;
   logic [7:0]  out8;
   logic [2:0]  idx8;
   logic        wrap8;

   logic        en6 = 1'b0, mode6 = 1'b0, dir6 = 1'b0, vld6 = 1'b0;
   logic [2:0]  sel6 = '0;
   logic [23:0] dwell6 = '0;
   logic [5:0]  out6;
   logic [2:0]  idx6;
   logic        wrap6;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   onehot_decoder_scan #(.SEL_W(3), .OUT_W(8), .DWELL_W(24)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8), .dir(dir8),
      .sel(sel8), .sel_vld(vld8), .dwell(dwell8),
      .out(out8), .idx(idx8), .wrap(wrap8)
   );

   onehot_decoder_scan #(.SEL_W(3), .OUT_W(6), .DWELL_W(24)) dut6 (
      .clk(clk), .rst(rst), .en(en6), .mode(mode6), .dir(dir6),
      .sel(sel6), .sel_vld(vld6), .dwell(dwell6),
      .out(out6), .idx(idx6), .wrap(wrap6)
   );

   task automatic apply8(input stim_t s);
      en8 = s.en; mode8 = s.mode; dir8 = s.dir;
      sel8 = s.sel; vld8 = s.vld; dwell8 = s.dwell;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // ----------------------------------------------------------------
   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      next_edge();
      next_edge();
      sb.push_back('{8'h00, 3'd0, 1'b0});
      sb.push_back('{8'h00, 3'd0, 1'b0});
      e = sb.pop_front();
      n_checks++;
      if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
         n_fail++;
         $display("FAIL reset8: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                  out8, idx8, wrap8, e.out, e.idx, e.wrap);
      end
      e = sb.pop_front();
      n_checks++;
      if ({2'b00, out6, idx6, wrap6} !== {e.out, e.idx, e.wrap}) begin
         n_fail++;
         $display("FAIL reset6: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                  out6, idx6, wrap6, e.out, e.idx, e.wrap);
      end
      rst = 1'b0;
   endtask

   // ----------------------------------------------------------------
   task automatic test_direct();
      stim_t st [6];
      exp_t  ex [6];
      exp_t  e;
      st = '{'{1'b1,1'b0,1'b0,3'd5,1'b1,24'd0},   // capture 5
             '{1'b1,1'b0,1'b0,3'd2,1'b0,24'd0},   // no strobe: hold
             '{1'b1,1'b0,1'b0,3'd2,1'b1,24'd0},   // capture 2
             '{1'b0,1'b0,1'b0,3'd7,1'b1,24'd0},   // OFF ignores strobe
             '{1'b1,1'b0,1'b0,3'd7,1'b0,24'd0},   // re-enable restores 2
             '{1'b1,1'b0,1'b0,3'd7,1'b1,24'd0}};  // top index
      ex = '{'{8'h20,3'd5,1'b0}, '{8'h20,3'd5,1'b0}, '{8'h04,3'd2,1'b0},
             '{8'h00,3'd2,1'b0}, '{8'h04,3'd2,1'b0}, '{8'h80,3'd7,1'b0}};
      for (int i = 0; i < 6; i++) begin
         apply8(st[i]);
         sb.push_back(ex[i]);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL direct[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out8, idx8, wrap8, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   task automatic test_out_of_range6();
      stim_t st [10];
      exp_t  ex [10];
      exp_t  e;
      st = '{'{1'b1,1'b0,1'b0,3'd2,1'b1,24'd0},   // capture 2
             '{1'b1,1'b0,1'b0,3'd7,1'b1,24'd0},   // 7 >= 6: ignored
             '{1'b1,1'b0,1'b0,3'd6,1'b1,24'd0},   // 6 >= 6: ignored
             '{1'b1,1'b0,1'b0,3'd5,1'b1,24'd0},   // capture 5
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd1},   // enter SCAN up
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd1},   // 5 -> 0 wraps
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd1},
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd1},   // down 1 -> 0, no wrap
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd1},   // 0 -> 5 wraps
             '{1'b0,1'b1,1'b1,3'd0,1'b0,24'd1}};  // blank
      ex = '{'{8'h04,3'd2,1'b0}, '{8'h04,3'd2,1'b0}, '{8'h04,3'd2,1'b0},
             '{8'h20,3'd5,1'b0}, '{8'h20,3'd5,1'b0}, '{8'h01,3'd0,1'b1},
             '{8'h02,3'd1,1'b0}, '{8'h01,3'd0,1'b0}, '{8'h20,3'd5,1'b1},
             '{8'h00,3'd5,1'b0}};
      for (int i = 0; i < 10; i++) begin
         en6 = st[i].en; mode6 = st[i].mode; dir6 = st[i].dir;
         sel6 = st[i].sel; vld6 = st[i].vld; dwell6 = st[i].dwell;
         sb.push_back(ex[i]);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({2'b00, out6, idx6, wrap6} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL range6[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out6, idx6, wrap6, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   task automatic test_scan_up_wrap();
      stim_t st [9];
      exp_t  ex [9];
      exp_t  e;
      st = '{'{1'b1,1'b0,1'b0,3'd6,1'b1,24'd3},   // DIRECT capture 6
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},   // enter SCAN
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},   // step to 7
             '{1'b1,1'b1,1'b0,3'd3,1'b1,24'd3},   // strobe ignored in SCAN
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3},   // step to 0, wrap
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd3}};  // wrap drops
      ex = '{'{8'h40,3'd6,1'b0}, '{8'h40,3'd6,1'b0}, '{8'h40,3'd6,1'b0},
             '{8'h40,3'd6,1'b0}, '{8'h80,3'd7,1'b0}, '{8'h80,3'd7,1'b0},
             '{8'h80,3'd7,1'b0}, '{8'h01,3'd0,1'b1}, '{8'h01,3'd0,1'b0}};
      for (int i = 0; i < 9; i++) begin
         apply8(st[i]);
         sb.push_back(ex[i]);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL scan_up[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out8, idx8, wrap8, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   task automatic test_scan_down_dwell0();
      stim_t st [7];
      exp_t  ex [7];
      exp_t  e;
      st = '{'{1'b1,1'b0,1'b1,3'd2,1'b1,24'd0},   // DIRECT capture 2
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd0},   // enter SCAN down
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd0},
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd0},
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd0},   // 0 -> 7 wraps
             '{1'b1,1'b1,1'b1,3'd0,1'b0,24'd0},
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd0}};  // reverse to up
      ex = '{'{8'h04,3'd2,1'b0}, '{8'h04,3'd2,1'b0}, '{8'h02,3'd1,1'b0},
             '{8'h01,3'd0,1'b0}, '{8'h80,3'd7,1'b1}, '{8'h40,3'd6,1'b0},
             '{8'h80,3'd7,1'b0}};
      for (int i = 0; i < 7; i++) begin
         apply8(st[i]);
         sb.push_back(ex[i]);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL scan_down[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out8, idx8, wrap8, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   // dwell = 10 while sitting on idx 7: count to 6, blank for 4 cycles,
   // re-enable (count restarts), count to 6 again, then lower dwell to 4
   // so the live compare forces a step on the very next edge.
   task automatic test_enable_dwell();
      stim_t s;
      exp_t  x;
      exp_t  e;
      for (int i = 0; i < 19; i++) begin
         s = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 24'd10};
         x = '{8'h80, 3'd7, 1'b0};
         if (i >= 6 && i <= 9) begin
            s.en = 1'b0;
            x.out = 8'h00;
         end
         if (i == 17) begin
            s.dwell = 24'd4;
            x = '{8'h01, 3'd0, 1'b1};
         end
         if (i == 18) begin
            s.dwell = 24'd4;
            x = '{8'h01, 3'd0, 1'b0};
         end
         apply8(s);
         sb.push_back(x);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL en_dwell[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out8, idx8, wrap8, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   task automatic test_async_reset();
      stim_t st [3];
      exp_t  ex [3];
      exp_t  e;
      // Step down 0 -> 7 so wrap is high when reset hits
      apply8('{1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 24'd1});
      sb.push_back('{8'h80, 3'd7, 1'b1});
      next_edge();
      e = sb.pop_front();
      n_checks++;
      if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
         n_fail++;
         $display("FAIL arst_pre: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                  out8, idx8, wrap8, e.out, e.idx, e.wrap);
      end
      // Assert between edges and look before the next rising edge
      #3;
      rst = 1'b1;
      sb.push_back('{8'h00, 3'd0, 1'b0});
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
         n_fail++;
         $display("FAIL arst_now: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                  out8, idx8, wrap8, e.out, e.idx, e.wrap);
      end
      next_edge();
      rst = 1'b0;
      st = '{'{1'b0,1'b1,1'b0,3'd0,1'b0,24'd1},   // still OFF after release
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd1},   // enter SCAN at idx 0
             '{1'b1,1'b1,1'b0,3'd0,1'b0,24'd1}};  // step to 1
      ex = '{'{8'h00,3'd0,1'b0}, '{8'h01,3'd0,1'b0}, '{8'h02,3'd1,1'b0}};
      for (int i = 0; i < 3; i++) begin
         apply8(st[i]);
         sb.push_back(ex[i]);
         next_edge();
         e = sb.pop_front();
         n_checks++;
         if ({out8, idx8, wrap8} !== {e.out, e.idx, e.wrap}) begin
            n_fail++;
            $display("FAIL arst_post[%0d]: out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
                     i, out8, idx8, wrap8, e.out, e.idx, e.wrap);
         end
      end
   endtask

   // ----------------------------------------------------------------
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_direct();
      test_out_of_range6();
      test_scan_up_wrap();
      test_scan_down_dwell0();
      test_enable_dwell();
      test_async_reset();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_onehot_decoder_scan
`default_nettype wire

// File: doc/onehot_decoder_scan.md
Name: onehot_decoder_scan

Overview:
- Parametrised registered N-to-2^N one-hot decoder; the next generation of our fixed 3-to-8 decoder.
- Adds an enable, a registered direct-select mode and an auto-scan mode.
- Auto-scan steps the active output up or down after a programmable number of cycles per step, and flags wrap-around.
- Drives LED / digit-select lines on board designs; `out` can feed pins directly because it is registered.

Parameters:
- SEL_W, 3, width of the select/index.
- OUT_W, 2**SEL_W, number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL_W, 24, width of the dwell-count input.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = active; 0 = output blanked, state held.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- dir  input  1  scan direction; 0 = up, 1 = down.
- sel  input  SEL_W  select value used in DIRECT mode.
- sel_vld  input  1  capture strobe for `sel`.
- dwell  input  DWELL_W  clock cycles each output stays active in SCAN; 0 is treated as 1.
- out  output  OUT_W  registered one-hot output.
- idx  output  SEL_W  registered current index.
- wrap  output  1  one-cycle pulse when the scan wraps.

Behaviour:
- Reset (asynchronous, on `rst` high):
  - state = OFF, `idx` = 0, `out` = 0, `wrap` = 0, dwell counter `cnt` = 0.
  - `rst` asserted mid-operation clears all of these immediately, without waiting for a clock edge.
- State machine (states OFF, DIRECT, SCAN), evaluated every cycle:
  - next state = OFF if `en` = 0.
  - Otherwise next state = DIRECT if `mode` = 0, SCAN if `mode` = 1.
  - Transitions are allowed between any pair of states.
- Output rule (registered):
  - `out` = (1 << next `idx`) when next state is not OFF; otherwise 0.
  - `out` and `idx` always update on the same edge, so `out` never disagrees with `idx` when enabled.
- OFF:
  - `out` = 0.
  - `idx` and `cnt` hold their values.
  - `sel_vld` is ignored.
  - `wrap` = 0.
- DIRECT:
  - If `sel_vld` = 1 at edge t and `sel` < OUT_W: `idx` = `sel` and `out` = one-hot of `sel`, visible after edge t (1-cycle latency).
  - If `sel` >= OUT_W: the capture is ignored; `idx` and `out` are unchanged.
  - `cnt` is held at 0.
  - `wrap` = 0.
- SCAN:
  - Effective dwell: `dw` = max(`dwell`, 1).
  - Terminal condition: `cnt` >= `dw` - 1. This comparison uses the live `dwell` value, so lowering `dwell` mid-count forces a step on the next edge.
  - When the terminal condition holds: `cnt` = 0 and `idx` steps.
    - Up: `idx` + 1, with OUT_W-1 wrapping to 0.
    - Down: `idx` - 1, with 0 wrapping to OUT_W-1.
  - Otherwise: `cnt` + 1, `idx` held.
  - `wrap` = 1 for exactly the cycle in which the new `idx` is the wrapped value (0 going up, OUT_W-1 going down).
  - `sel_vld` is ignored.
  - With `dwell` = 0 or 1, the output steps every cycle.
  - A change of `dir` takes effect at the next step; `cnt` is not disturbed.
- Mode changes:
  - Entering SCAN from DIRECT or OFF clears `cnt` to 0 and keeps `idx`. The first step occurs `dw` cycles after entry.
  - Entering DIRECT from SCAN keeps `idx` and clears `cnt`.
  - Re-enabling from OFF restores `out` to one-hot of the held `idx` on the first enabled edge.
- Non-power-of-two OUT_W:
  - Index values >= OUT_W are never produced.
  - Output bits above OUT_W-1 do not exist.
- Widths: `cnt` is DWELL_W bits wide; the comparison against `dw` - 1 is unsigned and cannot overflow.

Decomposition:
- Shared package `decoder_pkg`:
  - State encoding: OFF = 2'd0, DIRECT = 2'd1, SCAN = 2'd2.
  - Mode constants: MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1.
  - Direction constants: DIR_UP = 1'b0, DIR_DN = 1'b1.
- One sub-module, `scan_tick_gen`:
  - Contains the dwell counter (`cnt`, `dw` clamp, terminal compare).
  - Ports: `clk`, `rst`, `clr`, `run`, `dwell` -> `tick`.
- The top level holds the FSM, the index stepping/wrap logic and the output register.

Test Plan:
- Reset and direct decode: assert `rst`; check `out` = 0, `idx` = 0. Then `en` = 1, `mode` = 0, pulse `sel_vld` with `sel` = 5 → one cycle later `out` = 8'b0010_0000, `idx` = 5.
- Out-of-range select (OUT_W = 6): `sel` = 7 with `sel_vld` → `out` and `idx` unchanged. Then `sel` = 5 → `out` = 6'b10_0000.
- Scan up with wrap: `mode` = 1, `dwell` = 3, `idx` = 6 → after 3 cycles `idx` = 7; after 3 more `idx` = 0, `out` = 8'b0000_0001, and `wrap` = 1 for that single cycle only.
- Scan down with dwell = 0: `dir` = 1 → `idx` sequence 2, 1, 0, 7, 6 on consecutive cycles; `wrap` = 1 only on the cycle `idx` becomes 7.
- Enable and dwell changes: during SCAN with `dwell` = 10 and `cnt` = 6, drop `en` for 4 cycles → `out` = 0 and `idx` held. Restore `en` → `out` = one-hot of the held `idx`. Set `dwell` = 4 → step on the next edge.
- Asynchronous reset mid-scan: assert `rst` between clock edges → `out` = 0 and `wrap` = 0 immediately, before the next edge. Release `rst` → state OFF until `en` and `mode` are re-evaluated.
